nand_page_reader: RTL

- Command sequencer for one small-page NAND flash port (512-byte pages, 512 pages, 256 KiB).
- Accepts a page number, issues the read command and address cycles, and waits on ready/busy.
- Streams the 512 data bytes out over a valid/ready interface with backpressure.
- Sits between the NFC core and a flash port. The copy engine instantiates one per source flash, and a writer counterpart drives the destination.

---
 rtl/nfc_pkg.sv | 29 ++
 rtl/nand_wr_cycle.sv | 40 ++++
 rtl/nand_page_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash controller blocks: opcodes,
// small-page geometry and the page reader state encoding.
package nfc_pkg;

  localparam logic [7:0] CMD_READ0     = 8'h00;
  localparam logic [7:0] CMD_PROG      = 8'h80;
  localparam logic [7:0] CMD_PROG_CONF = 8'h10;
  localparam logic [7:0] CMD_ERASE1    = 8'h60;
  localparam logic [7:0] CMD_ERASE2    = 8'hD0;

  localparam int GEO_PAGE_BYTES = 512;
  localparam int GEO_PAGE_AW    = 9;
  localparam int GEO_NUM_PAGES  = 512;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_ADR0   = 4'd2,
    ST_ADR1   = 4'd3,
    ST_ADR2   = 4'd4,
    ST_WBUSY  = 4'd5,
    ST_WREADY = 4'd6,
    ST_RLO    = 4'd7,
    ST_RHI    = 4'd8,
    ST_OUT    = 4'd9,
    ST_FIN    = 4'd10
  } rd_state_e;

endpackage

// File: rtl/nand_wr_cycle.sv
// One latched flash write cycle: while en is high the byte and latch enables
// are driven, f_wen is low for WE_LO cycles then high for WE_HI cycles of
// hold time. fin marks the final hold cycle so the owner can advance.
module nand_wr_cycle #(
  parameter int WE_LO = 1,
  parameter int WE_HI = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cle,
  input  logic       ale,
  input  logic [7:0] wbyte,
  output logic [7:0] f_io_out,
  output logic       f_io_oe,
  output logic       f_cle,
  output logic       f_ale,
  output logic       f_wen,
  output logic       fin
);

  localparam int CW = $clog2(WE_LO + WE_HI + 1);

  logic [CW-1:0] cnt;

  // Phase counter restarts at every cycle boundary so back-to-back cycles chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (!en || fin) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  assign fin      = en && (cnt == CW'(WE_LO + WE_HI - 1));
  assign f_wen    = !(en && (cnt < CW'(WE_LO)));
  assign f_io_oe  = en;
  assign f_io_out = en ? wbyte : 8'h00;
  assign f_cle    = en && cle;
  assign f_ale    = en && ale;

endmodule

// File: rtl/nand_page_reader.sv
// Small-page NAND read sequencer: command + three address cycles, wait on
// ready/busy, then stream PAGE_BYTES bytes out.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid and its payload hold steady until that edge, and
// valid never depends combinationally on ready.
module nand_page_reader
  import nfc_pkg::*;
#(
  parameter int PAGE_BYTES = 512,
  parameter int PAGE_AW    = 9,
  parameter int WE_LO      = 1,
  parameter int WE_HI      = 1,
  parameter int RE_LO      = 1,
  parameter int RE_HI      = 1,
  parameter int BUSY_WAIT  = 16,
  parameter int READY_TO   = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PAGE_AW-1:0] req_page,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [7:0]         rd_data,
  output logic               rd_last,
  output logic               done,
  output logic               err,
  input  logic [7:0]         f_io_in,
  output logic [7:0]         f_io_out,
  output logic               f_io_oe,
  output logic               f_cle,
  output logic               f_ale,
  output logic               f_wen,
  output logic               f_ren,
  input  logic               f_rb,
  output logic [3:0]         dbg_state
);

  localparam int BW   = $clog2(PAGE_BYTES);
  localparam int WMAX = (READY_TO > BUSY_WAIT) ? READY_TO : BUSY_WAIT;
  localparam int WCW  = $clog2(WMAX + 1);

  rd_state_e          state_q, state_d;
  logic [WCW-1:0]     wcnt;
  logic [BW-1:0]      bcnt;
  logic [PAGE_AW-1:0] page_q;
  logic [15:0]        page_ext;
  logic               rb_s1, rb_s2;
  logic               wr_en, wr_cle, wr_ale, wr_fin;
  logic [7:0]         wr_byte;
  logic               is_last;

  assign page_ext  = 16'(page_q);
  assign is_last   = (bcnt == BW'(PAGE_BYTES - 1));
  assign req_ready = (state_q == ST_IDLE);
  assign rd_valid  = (state_q == ST_OUT);
  assign rd_last   = (state_q == ST_OUT) && is_last;
  assign done      = (state_q == ST_FIN);
  assign f_ren     = (state_q != ST_RLO);
  assign dbg_state = state_q;

  // Two-flop synchroniser for the asynchronous ready/busy pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_s1 <= 1'b1;
      rb_s2 <= 1'b1;
    end else begin
      rb_s1 <= f_rb;
      rb_s2 <= rb_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_CMD;
      ST_CMD:    if (wr_fin) state_d = ST_ADR0;
      ST_ADR0:   if (wr_fin) state_d = ST_ADR1;
      ST_ADR1:   if (wr_fin) state_d = ST_ADR2;
      ST_ADR2:   if (wr_fin) state_d = ST_WBUSY;
      ST_WBUSY:  if (!rb_s2 || wcnt == WCW'(BUSY_WAIT - 1)) state_d = ST_WREADY;
      ST_WREADY: begin
        if (rb_s2)                           state_d = ST_RLO;
        else if (wcnt == WCW'(READY_TO - 1)) state_d = ST_FIN;
      end
      ST_RLO:    if (wcnt == WCW'(RE_LO - 1)) state_d = ST_RHI;
      ST_RHI:    if (wcnt == WCW'(RE_HI - 1)) state_d = ST_OUT;
      ST_OUT:    if (rd_ready) state_d = is_last ? ST_FIN : ST_RLO;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Byte and latch enables for the command/address write cycles.
  always_comb begin
    wr_en   = 1'b0;
    wr_cle  = 1'b0;
    wr_ale  = 1'b0;
    wr_byte = 8'h00;
    case (state_q)
      ST_CMD:  begin wr_en = 1'b1; wr_cle = 1'b1; wr_byte = CMD_READ0;      end
      ST_ADR0: begin wr_en = 1'b1; wr_ale = 1'b1; wr_byte = 8'h00;          end
      ST_ADR1: begin wr_en = 1'b1; wr_ale = 1'b1; wr_byte = page_ext[7:0];  end
      ST_ADR2: begin wr_en = 1'b1; wr_ale = 1'b1; wr_byte = page_ext[15:8]; end
      default: ;
    endcase
  end

  // Dwell counter for the wait and read-strobe states; zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wcnt <= '0;
    else if (state_d != state_q)               wcnt <= '0;
    else if (state_q inside {ST_WBUSY, ST_WREADY, ST_RLO, ST_RHI})
                                               wcnt <= wcnt + 1'b1;
  end

  // Request latch, byte counter, data capture and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q  <= '0;
      bcnt    <= '0;
      rd_data <= 8'h00;
      err     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        page_q <= req_page;
        bcnt   <= '0;
        err    <= 1'b0;
      end
      if (state_q == ST_WREADY && state_d == ST_FIN) err <= 1'b1;
      if (state_q == ST_RLO && wcnt == WCW'(RE_LO - 1)) rd_data <= f_io_in;
      if (state_q == ST_OUT && rd_ready) bcnt <= bcnt + 1'b1;
    end
  end

  nand_wr_cycle #(
    .WE_LO (WE_LO),
    .WE_HI (WE_HI)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .en       (wr_en),
    .cle      (wr_cle),
    .ale      (wr_ale),
    .wbyte    (wr_byte),
    .f_io_out (f_io_out),
    .f_io_oe  (f_io_oe),
    .f_cle    (f_cle),
    .f_ale    (f_ale),
    .f_wen    (f_wen),
    .fin      (wr_fin)
  );

endmodule
